// File: rtl/counter_checker_if.sv
// Sample stream and result bundle between a counter-watching source and
// the sequence checker.
//
// Handshake: value_in and dut_reset are meaningful only in a cycle where
// value_valid=1; the checker is always ready, so every valid cycle is one
// consumed sample. Results are registered and show up the cycle after the
// sample.
interface counter_checker_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] value_in;
    logic             value_valid;
    logic             dut_reset;
    logic             locked;
    logic [WIDTH-1:0] expected;
    logic             error;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_bad;
    // Debug view of the checker FSM: 0 = UNLOCKED, 1 = LOCKED.
    logic             fsm_state;

    modport master (
        output value_in, value_valid, dut_reset,
        input  locked, expected, error, err_count, last_bad, fsm_state
    );

    modport slave (
        input  value_in, value_valid, dut_reset,
        output locked, expected, error, err_count, last_bad, fsm_state
    );
endinterface

// File: rtl/counter_checker.sv
// Sequence checker for a free-running up counter. It locks after LOCK_LEN
// consecutive +1 steps, then flags every sample that is neither the next
// value nor a zero taken while the counter is held in reset. A mismatch
// drops the lock and re-syncs starting from the offending sample.
module counter_checker #(
    parameter int WIDTH    = 8,
    parameter int ERR_W    = 8,
    parameter int LOCK_LEN = 2
) (
    input  logic        clk,
    input  logic        reset,
    counter_checker_if.slave bus
);
    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_LEN);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           cur_state, nxt_state;
    logic [RUN_W-1:0] run, nxt_run;
    logic [WIDTH-1:0] ref_val, nxt_ref;
    logic             have_ref, nxt_have_ref;
    logic [WIDTH-1:0] expected, nxt_expected;
    logic             error, nxt_error;
    logic [ERR_W-1:0] err_count, nxt_err_count;
    logic [WIDTH-1:0] last_bad, nxt_last_bad;

    // Register every piece of checker state; reset wins over any sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= UNLOCKED;
            run       <= '0;
            ref_val   <= '0;
            have_ref  <= 1'b0;
            expected  <= '0;
            error     <= 1'b0;
            err_count <= '0;
            last_bad  <= '0;
        end else begin
            cur_state <= nxt_state;
            run       <= nxt_run;
            ref_val   <= nxt_ref;
            have_ref  <= nxt_have_ref;
            expected  <= nxt_expected;
            error     <= nxt_error;
            err_count <= nxt_err_count;
            last_bad  <= nxt_last_bad;
        end
    end

    // Next-state logic: track the run while unlocked, verify while locked.
    always_comb begin
        nxt_state     = cur_state;
        nxt_run       = run;
        nxt_ref       = ref_val;
        nxt_have_ref  = have_ref;
        nxt_expected  = expected;
        nxt_error     = 1'b0;
        nxt_err_count = err_count;
        nxt_last_bad  = last_bad;

        if (bus.value_valid) begin
            case (cur_state)
                UNLOCKED: begin
                    // dut_reset is irrelevant here; every sample just feeds
                    // the run detector.
                    nxt_ref = bus.value_in;
                    if (!have_ref) begin
                        nxt_have_ref = 1'b1;
                        nxt_run      = '0;
                    end else if (bus.value_in == ref_val + ONE) begin
                        if (run + 1'b1 == LOCK_RUN) begin
                            nxt_state    = LOCKED;
                            nxt_expected = bus.value_in + ONE;
                            nxt_run      = '0;
                        end else begin
                            nxt_run = run + 1'b1;
                        end
                    end else begin
                        nxt_run = '0;
                    end
                end
                LOCKED: begin
                    if (bus.dut_reset) begin
                        // A counter held in reset must show zero; anything
                        // else during reset is a fault.
                        if (bus.value_in == ZERO) begin
                            nxt_expected = ONE;
                        end else begin
                            nxt_error = 1'b1;
                        end
                    end else if (bus.value_in == expected) begin
                        nxt_expected = expected + ONE;
                    end else begin
                        nxt_error = 1'b1;
                    end

                    if (nxt_error) begin
                        nxt_last_bad = bus.value_in;
                        if (err_count != ERR_MAX) begin
                            nxt_err_count = err_count + 1'b1;
                        end
                        // The bad sample seeds the re-sync run.
                        nxt_state    = UNLOCKED;
                        nxt_ref      = bus.value_in;
                        nxt_have_ref = 1'b1;
                        nxt_run      = '0;
                    end
                end
                default: begin
                    nxt_state = UNLOCKED;
                end
            endcase
        end
    end

    assign bus.locked    = (cur_state == LOCKED);
    assign bus.expected  = expected;
    assign bus.error     = error;
    assign bus.err_count = err_count;
    assign bus.last_bad  = last_bad;
    assign bus.fsm_state = cur_state;

endmodule
